// File: rtl/softmax_tile_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_tile_feeder
//  Description : Transmit side of the softmax_vec tile interface. Loads one
//                row of TOTAL_ELEMENTS scalars from a valid/ready stream,
//                pulses start, then replays the row as TILE_SIZE-wide beats
//                separated by GAP_CYCLES idle cycles. The next row is not
//                accepted until softmax_vec reports done.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_data    - upstream element stream (in)
//                in_ready            - feeder accepts an element (out)
//                en, start           - softmax_vec enable / row-start pulse
//                X_tile_in           - tile data, element 0 in the MSBs
//                tile_in_valid       - tile beat valid
//                done                - softmax_vec row complete (in)
//                busy, row_done      - row in flight / row-complete pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_tile_feeder #(
    parameter int WIDTH          = 32,
    parameter int TOTAL_ELEMENTS = 16,
    parameter int TILE_SIZE      = 4,
    parameter int GAP_CYCLES     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       en,
    output logic                       start,
    output logic [TILE_SIZE*WIDTH-1:0] X_tile_in,
    output logic                       tile_in_valid,
    input  logic                       done,
    output logic                       busy,
    output logic                       row_done
);

    localparam int c_NUM_TILES = TOTAL_ELEMENTS / TILE_SIZE;
    localparam int c_TILE_W    = (c_NUM_TILES > 1) ? $clog2(c_NUM_TILES) : 1;
    localparam int c_POS_W     = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int c_GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_TILE_W-1:0] c_LAST_TILE = c_TILE_W'(c_NUM_TILES - 1);
    localparam logic [c_POS_W-1:0]  c_LAST_POS  = c_POS_W'(TILE_SIZE - 1);
    localparam logic [c_GAP_W-1:0]  c_LAST_GAP  = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [2:0] S_LOAD      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_GAP       = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    generate
        if ((TILE_SIZE < 1) || (TOTAL_ELEMENTS < TILE_SIZE) ||
            (TOTAL_ELEMENTS % TILE_SIZE != 0) || (GAP_CYCLES < 0)) begin : g_bad_params
            $error("softmax_tile_feeder: TOTAL_ELEMENTS must be a non-zero multiple of TILE_SIZE");
        end
    endgenerate

    logic [2:0]                 r_state;
    logic [c_TILE_W-1:0]        r_ld_tile;   // write pointer, split as tile/position
    logic [c_POS_W-1:0]         r_ld_pos;
    logic [c_TILE_W-1:0]        r_tile;      // tile currently on X_tile_in
    logic [c_GAP_W-1:0]         r_gap;
    logic                       r_done_seen;
    logic [WIDTH-1:0]           r_buf [c_NUM_TILES][TILE_SIZE];

    logic                       r_in_ready;
    logic                       r_en;
    logic                       r_start;
    logic [TILE_SIZE*WIDTH-1:0] r_x;
    logic                       r_tile_valid;
    logic                       r_busy;
    logic                       r_row_done;

    logic                       w_accept;
    logic                       w_last_elem;
    logic [c_TILE_W-1:0]        w_next_tile;
    logic [TILE_SIZE*WIDTH-1:0] w_next_x;

    assign w_accept    = (r_state == S_LOAD) && in_valid && r_in_ready;
    assign w_last_elem = (r_ld_tile == c_LAST_TILE) && (r_ld_pos == c_LAST_POS);
    assign w_next_tile = (r_state == S_START) ? '0 : r_tile + 1'b1;

    // Element j of the tile lands in the j-th slot from the top.
    always_comb begin
        w_next_x = '0;
        for (int j = 0; j < TILE_SIZE; j++) begin
            w_next_x[(TILE_SIZE-1-j)*WIDTH +: WIDTH] = r_buf[w_next_tile][j];
        end
    end

    // Row buffer carries no reset; its contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_ld_tile][r_ld_pos] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_ld_tile    <= '0;
            r_ld_pos     <= '0;
            r_tile       <= '0;
            r_gap        <= '0;
            r_done_seen  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_en         <= 1'b0;
            r_start      <= 1'b0;
            r_x          <= '0;
            r_tile_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_row_done   <= 1'b0;
        end else begin
            r_en         <= 1'b1;
            r_start      <= 1'b0;
            r_tile_valid <= 1'b0;
            r_row_done   <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_last_elem) begin
                            r_state     <= S_START;
                            r_start     <= 1'b1;
                            r_busy      <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_done_seen <= 1'b0;
                            r_ld_tile   <= '0;
                            r_ld_pos    <= '0;
                        end else if (r_ld_pos == c_LAST_POS) begin
                            r_ld_pos  <= '0;
                            r_ld_tile <= r_ld_tile + 1'b1;
                        end else begin
                            r_ld_pos <= r_ld_pos + 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_state      <= S_SEND;
                    r_tile       <= w_next_tile;
                    r_tile_valid <= 1'b1;
                    r_x          <= w_next_x;
                end
                S_SEND: begin
                    if (done) begin
                        r_done_seen <= 1'b1;
                    end
                    if (r_tile == c_LAST_TILE) begin
                        // A done already seen (or arriving with the last beat)
                        // completes the row right after the final beat.
                        if (done || r_done_seen) begin
                            r_state    <= S_LOAD;
                            r_row_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_DONE;
                        end
                    end else if (GAP_CYCLES == 0) begin
                        r_tile       <= w_next_tile;
                        r_tile_valid <= 1'b1;
                        r_x          <= w_next_x;
                    end else begin
                        r_state <= S_GAP;
                        r_gap   <= '0;
                    end
                end
                S_GAP: begin
                    if (done) begin
                        r_done_seen <= 1'b1;
                    end
                    if (r_gap == c_LAST_GAP) begin
                        r_state      <= S_SEND;
                        r_tile       <= w_next_tile;
                        r_tile_valid <= 1'b1;
                        r_x          <= w_next_x;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (done || r_done_seen) begin
                        r_state    <= S_LOAD;
                        r_row_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign en            = r_en;
    assign start         = r_start;
    assign X_tile_in     = r_x;
    assign tile_in_valid = r_tile_valid;
    assign busy          = r_busy;
    assign row_done      = r_row_done;

endmodule
`default_nettype wire

// File: tb/tb_softmax_tile_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_tile_feeder
//  Description : Directed/randomized bench for softmax_tile_feeder. Instance
//                A uses the default geometry (16 elements, 4-wide tiles,
//                1-cycle gap); instance B uses 8-wide tiles with no gap.
//                Expected beats are rebuilt from the queue of accepted
//                elements and the documented row timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_tile_feeder;

    logic         clk = 1'b0;
    logic         rst;

    logic         a_in_valid, a_done;
    logic [31:0]  a_in_data;
    logic         a_in_ready, a_en, a_start, a_tv, a_busy, a_row_done;
    logic [127:0] a_x;

    logic         b_in_valid, b_done;
    logic [31:0]  b_in_data;
    logic         b_in_ready, b_en, b_start, b_tv, b_busy, b_row_done;
    logic [255:0] b_x;

    int           n_asserts = 0;
    int           n_fail    = 0;
    logic [31:0]  q[$];

    always #5 clk = ~clk;

    softmax_tile_feeder #(.WIDTH(32), .TOTAL_ELEMENTS(16), .TILE_SIZE(4), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .en(a_en), .start(a_start), .X_tile_in(a_x), .tile_in_valid(a_tv), .done(a_done),
        .busy(a_busy), .row_done(a_row_done)
    );

    softmax_tile_feeder #(.WIDTH(32), .TOTAL_ELEMENTS(16), .TILE_SIZE(8), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .en(b_en), .start(b_start), .X_tile_in(b_x), .tile_in_valid(b_tv), .done(b_done),
        .busy(b_busy), .row_done(b_row_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Tile k of the accepted row: first element of the tile ends up in the MSBs.
    function automatic logic [255:0] pack(input int k, input int n);
        logic [255:0] t = '0;
        for (int j = 0; j < n; j++) begin
            t = (t << 32) | 256'(q[k*n+j]);
        end
        return t;
    endfunction

    // pat 0: back-to-back 00010000+i, pat 1: valid on alternate cycles, pat 2: random valid.
    task automatic load_row(input int sel, input int pat);
        int          cyc;
        logic        v, rdy;
        logic [31:0] d;
        q.delete();
        cyc = 0;
        while (q.size() < 16 && cyc < 200) begin
            v = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            d = (pat == 0) ? 32'h0001_0000 + 32'(q.size()) : $urandom;
            if (sel == 0) begin a_in_valid = v; a_in_data = d; rdy = a_in_ready; end
            else          begin b_in_valid = v; b_in_data = d; rdy = b_in_ready; end
            tick();
            if (v && rdy) q.push_back(d);
            cyc++;
        end
        chk("load_count", 256'(q.size()), 256'd16);
        if (pat == 1) chk("bubble_cycles", 256'(cyc), 256'd31);
    endtask

    // Called in the cycle following the last accept (the expected start cycle).
    task automatic stream_row(input int sel, input int nt, input int gap, input int tile, input int done_cyc);
        int           last_beat, rd_cyc, k;
        logic         tv, st, rd, bz, ir;
        logic [255:0] x;
        logic         exp_tv;
        last_beat = 1 + (nt - 1) * (gap + 1);
        rd_cyc    = ((done_cyc > last_beat) ? done_cyc : last_beat) + 1;
        k = 0;
        for (int c = 0; c <= rd_cyc + 1; c++) begin
            if (sel == 0) begin tv = a_tv; st = a_start; rd = a_row_done; bz = a_busy; ir = a_in_ready; x = {128'b0, a_x}; end
            else          begin tv = b_tv; st = b_start; rd = b_row_done; bz = b_busy; ir = b_in_ready; x = b_x; end
            exp_tv = (c >= 1) && ((c - 1) % (gap + 1) == 0) && ((c - 1) / (gap + 1) < nt);
            chk("start", 256'(st), 256'(c == 0));
            chk("tile_valid", 256'(tv), 256'(exp_tv));
            if (exp_tv) begin
                chk("tile_data", x, pack(k, tile));
                k++;
            end else if (k > 0 && k < nt) begin
                chk("tile_hold", x, pack(k - 1, tile));
            end
            chk("row_done", 256'(rd), 256'(c == rd_cyc));
            chk("busy", 256'(bz), 256'(c < rd_cyc));
            if (c < rd_cyc)      chk("in_ready_stall", 256'(ir), 256'd0);
            if (c == rd_cyc + 1) chk("in_ready_back", 256'(ir), 256'd1);
            // Junk offered while stalled must never be captured.
            if (sel == 0) begin a_done = (c == done_cyc); a_in_valid = (c < rd_cyc); a_in_data = $urandom; end
            else          begin b_done = (c == done_cyc); b_in_valid = (c < rd_cyc); b_in_data = $urandom; end
            tick();
        end
        chk("beat_count", 256'(k), 256'(nt));
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 32'hDEAD_BEEF; a_done = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0;            b_done = 1'b0;

        // Reset held with traffic offered: everything stays low.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_outs", 256'({a_in_ready, a_en, a_start, a_tv, a_busy, a_row_done}), 256'd0);
            chk("rst_x", 256'(a_x), 256'd0);
        end
        rst = 1'b0;
        a_in_valid = 1'b0;
        tick();
        chk("post_rst_in_ready", 256'(a_in_ready), 256'd1);
        chk("post_rst_en", 256'(a_en), 256'd1);
        chk("post_rst_b_ready", 256'(b_in_ready), 256'd1);

        // Nominal row, done three cycles after the last beat.
        load_row(0, 0);
        chk("nominal_first_elem", 256'(q[0]), 256'h0001_0000);
        stream_row(0, 4, 1, 4, 10);

        // Upstream bubbles, done right after the last beat.
        load_row(0, 1);
        stream_row(0, 4, 1, 4, 8);

        // Early done during the gap before the last tile.
        load_row(0, 2);
        stream_row(0, 4, 1, 4, 6);

        // Random rows with random done timing.
        for (int r = 0; r < 3; r++) begin
            load_row(0, 2);
            stream_row(0, 4, 1, 4, int'($urandom_range(1, 12)));
        end

        // Reset during the second tile beat, then a clean row.
        load_row(0, 2);
        a_in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid_tv", 256'(a_tv), 256'd1);
        chk("mid_x", 256'(a_x), pack(1, 4));
        rst = 1'b1;
        tick();
        chk("mid_rst_outs", 256'({a_in_ready, a_en, a_start, a_tv, a_busy, a_row_done}), 256'd0);
        chk("mid_rst_x", 256'(a_x), 256'd0);
        rst = 1'b0;
        tick();
        chk("mid_rel_in_ready", 256'(a_in_ready), 256'd1);
        chk("mid_rel_row_done", 256'(a_row_done), 256'd0);
        load_row(0, 0);
        stream_row(0, 4, 1, 4, 9);

        // 8-wide tiles with no gap: two consecutive beats.
        load_row(1, 2);
        stream_row(1, 2, 0, 8, 3);
        load_row(1, 0);
        stream_row(1, 2, 0, 8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/softmax_tile_feeder.md
Name: softmax_tile_feeder

Overview:
- Transmit side of the softmax_vec tile interface.
- Collects one row of TOTAL_ELEMENTS scalar Q(WIDTH-FRAC_WIDTH).FRAC_WIDTH values from an upstream valid/ready stream into an internal buffer.
- Then issues a start pulse and replays the row as TILE_SIZE-wide tiles on X_tile_in/tile_in_valid, with a fixed idle gap between tiles.
- Waits for softmax_vec done before accepting the next row.

Parameters:
- WIDTH, 32, bits per element.
- TOTAL_ELEMENTS, 16, elements per row. Must be a multiple of TILE_SIZE; elaboration error otherwise.
- TILE_SIZE, 4, elements per tile.
- GAP_CYCLES, 1, idle cycles between consecutive tile_in_valid beats (0 allowed = back-to-back).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream element valid.
- in_data  in  WIDTH  upstream element.
- in_ready  out  1  feeder can accept an element.
- en  out  1  softmax_vec enable.
- start  out  1  one-cycle row-start pulse to softmax_vec.
- X_tile_in  out  TILE_SIZE*WIDTH  tile data to softmax_vec.
- tile_in_valid  out  1  tile beat valid.
- done  in  1  softmax_vec row complete.
- busy  out  1  row loaded and in flight (START..WAIT_DONE).
- row_done  out  1  one-cycle pulse when done is observed for the current row.

Behaviour:
- All outputs are registered.
- While rst=1:
  - state=LOAD, element/tile/gap counters=0, done_seen=0.
  - in_ready=0, en=0, start=0, tile_in_valid=0, X_tile_in=0, busy=0, row_done=0.
  - Buffer contents are don't-care.
- en=1 every cycle after rst deasserts.
- FSM states: LOAD, START, SEND, GAP, WAIT_DONE.
- LOAD:
  - in_ready=1, starting the first cycle after rst deasserts.
  - Accept on in_valid&in_ready; write buf[wr_cnt], then increment wr_cnt.
  - On the accept with wr_cnt==TOTAL_ELEMENTS-1: go to START. in_ready drops the next cycle; no further element is accepted.
  - done is ignored in LOAD.
- START: start=1 for exactly one cycle, busy=1, done_seen cleared. Next state SEND.
- SEND:
  - tile_in_valid=1 for one cycle with tile k.
  - Packing: X_tile_in[(TILE_SIZE-1-j)*WIDTH +: WIDTH] = buf[k*TILE_SIZE+j], i.e. element 0 of the tile in the MSBs.
  - If k is the last tile, go to WAIT_DONE. Else go to GAP if GAP_CYCLES>0, or stay in SEND with k+1 if GAP_CYCLES=0.
- GAP:
  - tile_in_valid=0 for GAP_CYCLES cycles, then SEND.
  - X_tile_in holds its last value; it changes only when a new beat is issued.
- Timing, with the last element accepted at edge T:
  - start high in cycle T+1.
  - Tile k valid in cycle T+2+k*(GAP_CYCLES+1).
  - Total beats = TOTAL_ELEMENTS/TILE_SIZE.
- done handling:
  - A done=1 in any cycle after the start cycle (SEND, GAP or WAIT_DONE) sets done_seen. This covers an early done while tiles are still being sent.
  - Tile sending still completes.
  - In WAIT_DONE, if done|done_seen: row_done=1 for one cycle, busy=0, state=LOAD, wr_cnt=0, in_ready=1 the following cycle.
- Concurrency: no overlap between rows; upstream stalls (in_ready=0) from the START cycle until the cycle after row_done.
- Reset mid-operation: abort immediately to the reset values; any partially loaded or in-flight row is discarded, with no row_done.
- Data is passed bit-exact; no arithmetic is performed on elements.

Test Plan:
- Reset: hold rst=1 for 5 cycles with in_valid=1 -> all outputs 0 throughout. in_ready=1 and en=1 the first cycle after release.
- Nominal row (defaults): stream in_data=32'h00010000+i for i=0..15, back-to-back -> start pulses one cycle after the 16th accept.
  - 4 beats, spaced 2 cycles apart.
  - First X_tile_in = {00010000,00010001,00010002,00010003}; last = {0001000C,...,0001000F}.
  - Drive done 3 cycles after the last beat -> row_done pulses in the next cycle; in_ready returns.
- Upstream bubbles: in_valid toggling 1,0,1,0 over 32 cycles -> exactly 16 elements captured, in order. During START/SEND, in_valid=1 with in_ready=0 is not captured.
- GAP_CYCLES=0, TILE_SIZE=8, TOTAL_ELEMENTS=16 -> 2 consecutive valid beats right after the start cycle, with correct 8-element packing.
- Early done: pulse done during the GAP before the last tile -> remaining tile still sent, then row_done the cycle after the last beat. No hang.
- Reset mid-row: assert rst during the second tile beat -> outputs 0 next cycle. A following full row starts cleanly from element 0.
